// File: rtl/seg_display_scanner.sv
// seg_display_scanner: eight-digit multiplexed hex display driver.
// x[15:0] shows on digits 7..4, y[15:0] on digits 3..0, latched per frame.
module seg_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 0
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        freeze,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic        frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [15:0]   sx;
    logic [15:0]   sy;
    logic          div_last;
    logic          frame_wrap;
    logic [15:0]   field;
    logic [3:0]    nib;
    logic          lead_zero;
    logic          blank;
    logic          unused_hi;

    assign unused_hi  = ^{x[31:16], y[31:16]};
    assign div_last   = (div_cnt == DIV_LAST);
    assign frame_wrap = div_last && (idx == 3'd7);
    assign blank      = (BLANK_LZ != 0) && lead_zero;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Refresh divider; the digit index steps on each terminal count.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_last) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Snapshot reloads only as the scan wraps to digit 0, so a frame never tears.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            sx <= '0;
            sy <= '0;
        end else if (frame_wrap && !freeze) begin
            sx <= x[15:0];
            sy <= y[15:0];
        end
    end

    // Select the current nibble and whether it and all higher nibbles are zero.
    always_comb begin
        field     = idx[2] ? sx : sy;
        nib       = 4'h0;
        lead_zero = 1'b0;
        case (idx[1:0])
            2'd0: begin
                nib       = field[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                nib       = field[7:4];
                lead_zero = (field[15:4] == 12'h000);
            end
            2'd2: begin
                nib       = field[11:8];
                lead_zero = (field[15:8] == 8'h00);
            end
            default: begin
                nib       = field[15:12];
                lead_zero = (field[15:12] == 4'h0);
            end
        endcase
    end

    // Registered segment, anode and frame-start outputs.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            out7       <= 7'h7F;
            en_out     <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            out7       <= blank ? 7'h7F : hex7(nib);
            en_out     <= ~(8'h01 << idx);
            frame_tick <= (idx == 3'd0) && (div_cnt == '0);
        end
    end

endmodule
